chirp_sweep_ctrl: RTL and testbench
===================================

# chirp_sweep_ctrl

Sequencer that drives the NCO frequency control word to produce linear chirps: sawtooth (up-ramp) or triangle (up/down) frequency sweeps, stepped at a programmable dwell, repeated a programmed number of times or continuously. Sits directly upstream of the NCO. Owns `ctrl` and the NCO reset, and reports busy/done status to the host-side configuration logic.

## Interface
- `N`, 32, width of the frequency control word; matches the NCO `N`
- `SW`, 16, width of the step-count field
- `DW`, 16, width of the dwell-count field
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a chirp; sampled only in IDLE
- `abort`  in  1  stop immediately; valid in any state
- `f_start`  in  N  first frequency word
- `f_step`  in  N  per-step increment, unsigned
- `n_steps`  in  SW  number of increments from the bottom of the ramp to the top
- `dwell`  in  DW  each frequency value is held for `dwell`+1 cycles
- `mode`  in  1  0 = sawtooth, 1 = triangle
- `n_sweeps`  in  8  sweeps to run; 0 = continuous until abort
- `ctrl_out`  out  N  frequency word to the NCO `ctrl` input
- `nco_rst`  out  1  to the NCO `rst` input; holds the phase at 0
- `busy`  out  1  high from PRIME through the final sweep cycle
- `done`  out  1  one-cycle pulse when all sweeps complete normally
- `sweep_wrap`  out  1  one-cycle pulse on the last cycle of every sweep

## Operation
- States: IDLE, PRIME, RAMP_UP, RAMP_DN.
- **IDLE**
  - `ctrl_out`=0, `nco_rst`=1, `busy`=0.
  - `start`=1 with `abort`=0 latches `f_start`, `f_step`, `n_steps`, `dwell`, `mode` and `n_sweeps` into internal registers, then moves to PRIME.
  - Input changes after the latch have no effect until the next IDLE.
- **PRIME** (1 cycle)
  - `ctrl_out`=`f_start`, `nco_rst`=1, `busy`=1, then moves to RAMP_UP.
  - PRIME does not count toward the dwell.
- **Step index k**
  - `ctrl_out` = `f_start` + k·`f_step`, computed modulo 2^N; the carry is discarded.
  - Implement as a running accumulator (add or subtract `f_step` per step). No multiplier.
- **Dwell counter**
  - Counts 0..`dwell`. The step advances on the cycle where the counter equals `dwell`.
- **RAMP_UP**
  - k runs 0..`n_steps`.
- **Sawtooth sweep**
  - Consists of k = 0..`n_steps`, i.e. `n_steps`+1 dwell periods.
- **Triangle sweep**
  - k runs 0..`n_steps` in RAMP_UP, then `n_steps`−1 down to 1 in RAMP_DN: 2·`n_steps` periods, with no repeated endpoint.
  - With `n_steps`=0, a triangle behaves as sawtooth.
- **End of a sweep**
  - `sweep_wrap`=1 on its last cycle, and the sweep counter increments.
  - If more sweeps remain (or `n_sweeps`=0), the next cycle starts the next sweep at k=0 in RAMP_UP, with no PRIME and `nco_rst` staying 0 (phase-continuous).
  - Otherwise the next cycle is IDLE with `done`=1 for exactly that cycle.
- **Sweep counter**
  - 8 bits. With `n_sweeps`=0 it does not terminate the run; it may wrap freely.
- **abort**
  - From any non-IDLE state, the next cycle is IDLE with IDLE outputs. `done` is not asserted and `sweep_wrap` is suppressed on the abort cycle.
- **Priority:** `rst` > `abort` > `start`. `start` while busy is ignored.
- **rst**
  - Mid-sweep reset behaves as abort, plus all registers are cleared.
  - Reset values: `ctrl_out`=0, `nco_rst`=1, `busy`=0, `done`=0, `sweep_wrap`=0, state IDLE.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- **Start at cycle T** (`start` sampled in IDLE):
  - T+1: PRIME.
  - T+2: first k=0 cycle with `nco_rst`=0.
- **Value changes:** each `ctrl_out` value is held exactly `dwell`+1 cycles. Consecutive values are back-to-back with no gap cycles, including across sweep boundaries.
- **Run end:**
  - `busy` falls on the same cycle `done` rises, one cycle after the last `sweep_wrap`.
  - `nco_rst` rises on that same cycle.
- **abort at cycle A:** IDLE outputs are present at A+1.
- **Back-to-back runs:** a new `start` is accepted in the cycle `done` is high (state is IDLE).
- **Run length:** sawtooth is 1 + `n_sweeps`·(`n_steps`+1)·(`dwell`+1) cycles from T+1 to `done`, exclusive.

## Test plan
- **Single sawtooth.** Inputs: `f_start`=0x1000, `f_step`=0x100, `n_steps`=3, `dwell`=1, saw, `n_sweeps`=1, start at T.
  - PRIME at T+1; `ctrl_out` 0x1000 at T+2..3, 0x1100 at T+4..5, 0x1200 at T+6..7, 0x1300 at T+8..9.
  - `sweep_wrap` at T+9; `done`=1, `busy`=0, `nco_rst`=1, `ctrl_out`=0 at T+10.
- **Triangle.** Same start/step, `n_steps`=2, `dwell`=0, `n_sweeps`=2.
  - `ctrl_out` from T+2: 1000, 1100, 1200, 1100, 1000, 1100, 1200, 1100.
  - `sweep_wrap` at T+5 and T+9; `done` at T+10; `nco_rst`=0 throughout T+2..T+9.
- **Wrap-around.** `f_start`=0xFFFFFF00, `f_step`=0x100, `n_steps`=2, `dwell`=0, saw.
  - `ctrl_out` = 0xFFFFFF00, 0x00000000, 0x00000100.
- **Abort.** Continuous run (`n_sweeps`=0) over ≥3 sweeps.
  - `sweep_wrap` every (`n_steps`+1)·(`dwell`+1) cycles, `nco_rst` never reasserts.
  - `abort` mid-dwell gives IDLE outputs next cycle and no `done`; a subsequent `start` runs normally.
- **Protocol edges.**
  - `start` while busy is ignored.
  - Input changes mid-sweep do not alter `ctrl_out`.
  - `start`+`abort` together in IDLE: stays IDLE.
  - `rst` mid-sweep: all outputs at reset values next cycle.
- **Minimum config.** `n_steps`=0, `dwell`=0, triangle, `n_sweeps`=3.
  - `ctrl_out`=`f_start` for 3 cycles, `sweep_wrap` each cycle, `done` on the 4th.

Source files
------------

// File: rtl/chirp_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chirp_sweep_ctrl
// Description : Linear chirp sequencer (sawtooth/triangle) driving an NCO ctrl word.
// Revision    : 1.0 - initial release
// ============================================================================
module chirp_sweep_ctrl #(
    parameter int N  = 32,
    parameter int SW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  f_start,
    input  logic [N-1:0]  f_step,
    input  logic [SW-1:0] n_steps,
    input  logic [DW-1:0] dwell,
    input  logic          mode,
    input  logic [7:0]    n_sweeps,
    output logic [N-1:0]  ctrl_out,
    output logic          nco_rst,
    output logic          busy,
    output logic          done,
    output logic          sweep_wrap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_UP    = 2'd2;
    localparam logic [1:0] S_DN    = 2'd3;

    logic [1:0]    r_state;
    logic [N-1:0]  r_f_start, r_f_step, r_acc;
    logic [SW-1:0] r_n_steps, r_k;
    logic [DW-1:0] r_dwell, r_dcnt;
    logic          r_mode;
    logic [7:0]    r_n_sweeps, r_sweeps;
    logic          r_nco_rst, r_busy, r_done, r_wrap;

    logic [1:0]    w_nxt_state;
    logic [N-1:0]  w_nxt_acc;
    logic [SW-1:0] w_nxt_k;
    logic [DW-1:0] w_nxt_dcnt;
    logic [7:0]    w_nxt_sweeps;
    logic          w_nxt_done, w_nxt_last, w_load;
    logic          w_tri, w_step_end, w_top, w_sweep_end, w_last_sweep;

    always_comb begin
        // A triangle with fewer than two steps has no down leg.
        w_tri        = r_mode && (r_n_steps > SW'(1));
        w_step_end   = (r_dcnt == r_dwell);
        w_top        = (r_k == r_n_steps);
        w_sweep_end  = w_step_end && (((r_state == S_UP) && w_top && !w_tri) ||
                                      ((r_state == S_DN) && (r_k == SW'(1))));
        w_last_sweep = (r_n_sweeps != 8'd0) && (r_sweeps == r_n_sweeps - 8'd1);

        w_nxt_state  = r_state;
        w_nxt_acc    = r_acc;
        w_nxt_k      = r_k;
        w_nxt_dcnt   = r_dcnt;
        w_nxt_sweeps = r_sweeps;
        w_nxt_done   = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_nxt_state = S_PRIME;
                    w_nxt_acc   = f_start;
                    w_load      = 1'b1;
                end
            end
            S_PRIME: begin
                w_nxt_state = S_UP;
                w_nxt_k     = '0;
                w_nxt_dcnt  = '0;
            end
            default: begin
                if (!w_step_end) begin
                    w_nxt_dcnt = r_dcnt + DW'(1);
                end else begin
                    w_nxt_dcnt = '0;
                    if (w_sweep_end) begin
                        w_nxt_sweeps = r_sweeps + 8'd1;
                        if (w_last_sweep) begin
                            w_nxt_state = S_IDLE;
                            w_nxt_acc   = '0;
                            w_nxt_done  = 1'b1;
                        end else begin
                            w_nxt_state = S_UP;
                            w_nxt_k     = '0;
                            w_nxt_acc   = r_f_start;
                        end
                    end else if ((r_state == S_UP) && !w_top) begin
                        w_nxt_k   = r_k + SW'(1);
                        w_nxt_acc = r_acc + r_f_step;
                    end else begin
                        w_nxt_state = S_DN;
                        w_nxt_k     = r_k - SW'(1);
                        w_nxt_acc   = r_acc - r_f_step;
                    end
                end
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_nxt_state = S_IDLE;
            w_nxt_acc   = '0;
            w_nxt_done  = 1'b0;
        end

        // sweep_wrap is registered, so flag the cycle before the sweep's last one.
        w_nxt_last = (w_nxt_dcnt == r_dwell) &&
                     (((w_nxt_state == S_UP) && (w_nxt_k == r_n_steps) && !w_tri) ||
                      ((w_nxt_state == S_DN) && (w_nxt_k == SW'(1))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_f_start  <= '0;
            r_f_step   <= '0;
            r_n_steps  <= '0;
            r_dwell    <= '0;
            r_mode     <= 1'b0;
            r_n_sweeps <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_dcnt     <= '0;
            r_sweeps   <= '0;
            r_nco_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_acc     <= w_nxt_acc;
            r_k       <= w_nxt_k;
            r_dcnt    <= w_nxt_dcnt;
            r_sweeps  <= w_nxt_sweeps;
            if (w_load) begin
                r_f_start  <= f_start;
                r_f_step   <= f_step;
                r_n_steps  <= n_steps;
                r_dwell    <= dwell;
                r_mode     <= mode;
                r_n_sweeps <= n_sweeps;
                r_sweeps   <= '0;
            end
            r_nco_rst <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_PRIME);
            r_busy    <= (w_nxt_state != S_IDLE);
            r_done    <= w_nxt_done;
            r_wrap    <= w_nxt_last;
        end
    end

    assign ctrl_out   = r_acc;
    assign nco_rst    = r_nco_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sweep_wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_chirp_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chirp_sweep_ctrl
// Description : Directed plus randomized bench for chirp_sweep_ctrl with a sweep-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chirp_sweep_ctrl;

    localparam logic [35:0] c_IDLE = {32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [31:0] fs;
        logic [31:0] fst;
        int          ns;
        int          dw;
        bit          mode;
        int          nsw;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, mode;
    logic [31:0] f_start, f_step;
    logic [15:0] n_steps, dwell;
    logic [7:0]  n_sweeps;
    logic [31:0] ctrl_out;
    logic        nco_rst, busy, done, sweep_wrap;
    logic [35:0] w_outs;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [35:0] exp_q[$];

    chirp_sweep_ctrl #(.N(32), .SW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
        .mode(mode), .n_sweeps(n_sweeps), .ctrl_out(ctrl_out), .nco_rst(nco_rst),
        .busy(busy), .done(done), .sweep_wrap(sweep_wrap)
    );

    always #5 clk = ~clk;
    assign w_outs = {ctrl_out, nco_rst, busy, done, sweep_wrap};

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs from PRIME onward: each sweep is a list of
    // step indices, each held for dwell+1 cycles.
    function automatic void build(input cfg_t c, input int sweeps, input bit with_done);
        int          ks[$];
        logic [31:0] val;
        exp_q.delete();
        exp_q.push_back({c.fs, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k <= c.ns; k++) ks.push_back(k);
        if (c.mode)
            for (int k = c.ns - 1; k >= 1; k--) ks.push_back(k);
        for (int s = 0; s < sweeps; s++)
            for (int j = 0; j < ks.size(); j++)
                for (int d = 0; d <= c.dw; d++) begin
                    val = c.fs + c.fst * 32'(ks[j]);
                    exp_q.push_back({val, 1'b0, 1'b1, 1'b0,
                                     (j == ks.size() - 1) && (d == c.dw)});
                end
        if (with_done) exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    endfunction

    task automatic apply(input cfg_t c);
        f_start  = c.fs;
        f_step   = c.fst;
        n_steps  = 16'(c.ns);
        dwell    = 16'(c.dw);
        mode     = c.mode;
        n_sweeps = 8'(c.nsw);
    endtask

    task automatic scramble();
        f_start  = $urandom;
        f_step   = $urandom;
        n_steps  = 16'($urandom_range(0, 7));
        dwell    = 16'($urandom_range(0, 3));
        mode     = 1'($urandom_range(0, 1));
        n_sweeps = 8'($urandom_range(0, 4));
        start    = 1'($urandom_range(0, 1));
    endtask

    // Runs one chirp; stop_at >= 0 interrupts it with abort (or rst) after that entry.
    task automatic do_run(input cfg_t c, input int sweeps, input bit with_done,
                          input int stop_at, input bit use_rst, input string name);
        build(c, sweeps, with_done);
        apply(c);
        abort = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), w_outs, exp_q[i]);
            if (i == stop_at) begin
                start = 1'b0;
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
                step();
                rst   = 1'b0;
                abort = 1'b0;
                check($sformatf("%s_stop", name), w_outs, c_IDLE);
                step();
                check($sformatf("%s_stop_hold", name), w_outs, c_IDLE);
                return;
            end
            if (i != exp_q.size() - 1) begin
                scramble();
                step();
            end
        end
        start = 1'b0;
    endtask

    initial begin
        cfg_t c;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_step = '0; n_steps = '0; dwell = '0; mode = 1'b0; n_sweeps = '0;
        step();
        step();
        check("reset", w_outs, c_IDLE);
        rst = 1'b0;
        step();
        check("idle_after_reset", w_outs, c_IDLE);

        c = '{fs: 32'h1000, fst: 32'h100, ns: 3, dw: 1, mode: 1'b0, nsw: 1};
        do_run(c, 1, 1'b1, -1, 1'b0, "saw");

        c = '{fs: 32'h1000, fst: 32'h100, ns: 2, dw: 0, mode: 1'b1, nsw: 2};
        do_run(c, 2, 1'b1, -1, 1'b0, "tri");

        c = '{fs: 32'hFFFF_FF00, fst: 32'h100, ns: 2, dw: 0, mode: 1'b0, nsw: 1};
        do_run(c, 1, 1'b1, -1, 1'b0, "wrap");

        c = '{fs: 32'hABCD_0123, fst: 32'h55, ns: 0, dw: 0, mode: 1'b1, nsw: 3};
        do_run(c, 3, 1'b1, -1, 1'b0, "min");

        c = '{fs: 32'h2000, fst: 32'h40, ns: 1, dw: 2, mode: 1'b1, nsw: 2};
        do_run(c, 2, 1'b1, -1, 1'b0, "tri_n1");

        // Continuous run, aborted mid-dwell inside the fourth sweep.
        c = '{fs: 32'h3000, fst: 32'h10, ns: 2, dw: 2, mode: 1'b0, nsw: 0};
        do_run(c, 4, 1'b0, 32, 1'b0, "cont_abort");

        c = '{fs: 32'h4000, fst: 32'h7, ns: 3, dw: 1, mode: 1'b1, nsw: 0};
        do_run(c, 3, 1'b0, 20, 1'b0, "cont_tri_abort");

        c = '{fs: 32'h1000, fst: 32'h100, ns: 3, dw: 1, mode: 1'b0, nsw: 1};
        do_run(c, 1, 1'b1, -1, 1'b0, "after_abort");

        start = 1'b1; abort = 1'b1;
        step();
        check("start_abort_idle", w_outs, c_IDLE);
        start = 1'b0; abort = 1'b0;
        step();
        check("start_abort_hold", w_outs, c_IDLE);

        c = '{fs: 32'h5555, fst: 32'h3, ns: 4, dw: 1, mode: 1'b1, nsw: 2};
        do_run(c, 2, 1'b1, 7, 1'b1, "mid_rst");

        for (int r = 0; r < 15; r++) begin
            c.fs   = $urandom;
            c.fst  = $urandom;
            c.ns   = $urandom_range(0, 5);
            c.dw   = $urandom_range(0, 3);
            c.mode = 1'($urandom_range(0, 1));
            c.nsw  = $urandom_range(1, 3);
            do_run(c, c.nsw, 1'b1, -1, 1'b0, $sformatf("rnd%0d", r));
        end

        step();
        check("final_idle", w_outs, c_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
